// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream writer and the panel driver.
// Holds the writer FSM state encoding, the RGB565 field widths, the
// frame-buffer bus widths, the write-lane constant and the pixel-to-write-data
// packing helper.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

    localparam int RGB_R_W = 5;
    localparam int RGB_G_W = 6;
    localparam int RGB_B_W = 5;
    localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    localparam int ADDR_W = 16;
    localparam int WDAT_W = 24;

    // Lanes 0..2 carry the 24-bit word; lane 3 is unused by this panel.
    localparam logic [3:0] CTRL_WR_LANES = 4'b0111;

    // The pixel goes out unmodified in the low bits of the write word.
    function automatic logic [WDAT_W-1:0] pix_to_wdat(input logic [PIX_W-1:0] pix);
        return {8'h00, pix};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_data      write request (ignored while full) and data
//   pop, pop_data        read request (ignored while empty) and head data
//   full, empty          registered occupancy flags
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push is decided on the occupancy before this cycle's pop.
    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next occupancy from this cycle's accepted push/pop.
    always_comb begin
        count_nxt_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and flags. full resets high so nothing is
    // accepted while reset is held; it drops on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b1;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_stream_writer.sv
// Pixel stream writer: buffers an RGB565 pixel stream and writes it in raster
// order into the panel frame buffer, tracking frame boundaries.
// Ports:
//   ctrl_clk, ctrl_resetn   clock, asynchronous active-low reset
//   s_valid/s_ready/s_sof/s_data   input pixel stream (s_sof marks frame start)
//   hold                    stall frame-buffer writes (input FIFO keeps filling)
//   ctrl_en/wr/addr/wdat    registered frame-buffer write port
//   frame_done              pulse with the write of the last pixel of a frame
//   err_short, err_long     saturating counts of short frames / over-long runs
module pixel_stream_writer
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                ctrl_clk,
    input  logic                ctrl_resetn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_sof,
    input  logic [PIX_W-1:0]    s_data,
    input  logic                hold,
    output logic                ctrl_en,
    output logic [3:0]          ctrl_wr,
    output logic [ADDR_W-1:0]   ctrl_addr,
    output logic [WDAT_W-1:0]   ctrl_wdat,
    output logic                frame_done,
    output logic [7:0]          err_short,
    output logic [7:0]          err_long
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [PIX_W:0]    fifo_dout_s;
    logic              pop_s;
    logic              pop_sof_s;
    logic [PIX_W-1:0]  pop_pix_s;

    wr_state_e         state_r;
    wr_state_e         state_nxt_s;
    logic [XW-1:0]     x_r;
    logic [YW-1:0]     y_r;
    logic [XW-1:0]     x_nxt_s;
    logic [YW-1:0]     y_nxt_s;
    logic [XW-1:0]     wr_x_s;
    logic [YW-1:0]     wr_y_s;
    logic              wr_en_s;
    logic              last_s;
    logic              short_inc_s;
    logic              long_inc_s;

    logic              ctrl_en_r;
    logic [3:0]        ctrl_wr_r;
    logic [ADDR_W-1:0] ctrl_addr_r;
    logic [WDAT_W-1:0] ctrl_wdat_r;
    logic              frame_done_r;
    logic [7:0]        err_short_r;
    logic [7:0]        err_long_r;

    sync_fifo #(
        .WIDTH (PIX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ctrl_clk),
        .rst_n     (ctrl_resetn),
        .push      (s_valid),
        .push_data ({s_sof, s_data}),
        .pop       (pop_s),
        .pop_data  (fifo_dout_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign s_ready   = !fifo_full_s;
    assign pop_s     = !fifo_empty_s && !hold;
    assign pop_sof_s = fifo_dout_s[PIX_W];
    assign pop_pix_s = fifo_dout_s[PIX_W-1:0];

    // Decide what the popped pixel does: write (and where), drop, or flag.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_x_s      = x_r;
        wr_y_s      = y_r;
        short_inc_s = 1'b0;
        long_inc_s  = 1'b0;
        if (pop_s) begin
            case (state_r)
                ST_WRITE: begin
                    wr_en_s = 1'b1;
                    // Any sof inside a frame means the frame was cut short.
                    if (pop_sof_s) begin
                        short_inc_s = 1'b1;
                        wr_x_s      = {XW{1'b0}};
                        wr_y_s      = {YW{1'b0}};
                    end else begin
                        wr_x_s = x_r;
                        wr_y_s = y_r;
                    end
                end
                ST_IDLE, ST_DROP: begin
                    if (pop_sof_s) begin
                        wr_en_s = 1'b1;
                        wr_x_s  = {XW{1'b0}};
                        wr_y_s  = {YW{1'b0}};
                    end else begin
                        // Only the first stray pixel of a run is counted.
                        long_inc_s = (state_r == ST_IDLE);
                    end
                end
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Raster advance and next state from the write decision above.
    always_comb begin
        state_nxt_s = state_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        last_s      = wr_en_s && (wr_x_s == X_LAST) && (wr_y_s == Y_LAST);
        if (wr_en_s) begin
            if (last_s) begin
                state_nxt_s = ST_IDLE;
                x_nxt_s     = {XW{1'b0}};
                y_nxt_s     = {YW{1'b0}};
            end else if (wr_x_s == X_LAST) begin
                state_nxt_s = ST_WRITE;
                x_nxt_s     = {XW{1'b0}};
                y_nxt_s     = wr_y_s + YW'(1);
            end else begin
                state_nxt_s = ST_WRITE;
                x_nxt_s     = wr_x_s + XW'(1);
                y_nxt_s     = wr_y_s;
            end
        end else if (pop_s && !pop_sof_s && (state_r != ST_WRITE)) begin
            state_nxt_s = ST_DROP;
        end else if (state_r != ST_IDLE && state_r != ST_WRITE && state_r != ST_DROP) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and raster position registers.
    always_ff @(posedge ctrl_clk or negedge ctrl_resetn) begin
        if (!ctrl_resetn) begin
            state_r <= ST_IDLE;
            x_r     <= {XW{1'b0}};
            y_r     <= {YW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
        end
    end

    // Registered frame-buffer port; address/data/lanes hold between writes.
    always_ff @(posedge ctrl_clk or negedge ctrl_resetn) begin
        if (!ctrl_resetn) begin
            ctrl_en_r    <= 1'b0;
            ctrl_wr_r    <= 4'b0000;
            ctrl_addr_r  <= {ADDR_W{1'b0}};
            ctrl_wdat_r  <= {WDAT_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            ctrl_en_r    <= wr_en_s;
            frame_done_r <= last_s;
            if (wr_en_s) begin
                ctrl_wr_r   <= CTRL_WR_LANES;
                ctrl_addr_r <= ADDR_W'({wr_x_s, wr_y_s});
                ctrl_wdat_r <= pix_to_wdat(pop_pix_s);
            end
        end
    end

    // Saturating error counters.
    always_ff @(posedge ctrl_clk or negedge ctrl_resetn) begin
        if (!ctrl_resetn) begin
            err_short_r <= 8'd0;
            err_long_r  <= 8'd0;
        end else begin
            if (short_inc_s && (err_short_r != 8'hFF)) begin
                err_short_r <= err_short_r + 8'd1;
            end
            if (long_inc_s && (err_long_r != 8'hFF)) begin
                err_long_r <= err_long_r + 8'd1;
            end
        end
    end

    assign ctrl_en    = ctrl_en_r;
    assign ctrl_wr    = ctrl_wr_r;
    assign ctrl_addr  = ctrl_addr_r;
    assign ctrl_wdat  = ctrl_wdat_r;
    assign frame_done = frame_done_r;
    assign err_short  = err_short_r;
    assign err_long   = err_long_r;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Self-checking bench for pixel_stream_writer: a reference model predicts each
// frame-buffer write when a pixel is accepted and queues it; a monitor pops and
// compares every write the DUT makes.
module tb_pixel_stream_writer;

    localparam int W = 64;
    localparam int H = 32;

    logic        ctrl_clk;
    logic        ctrl_resetn;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic [15:0] s_data;
    logic        hold;
    logic        ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        frame_done;
    logic [7:0]  err_short;
    logic [7:0]  err_long;

    pixel_stream_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
        .ctrl_clk    (ctrl_clk),
        .ctrl_resetn (ctrl_resetn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_sof       (s_sof),
        .s_data      (s_data),
        .hold        (hold),
        .ctrl_en     (ctrl_en),
        .ctrl_wr     (ctrl_wr),
        .ctrl_addr   (ctrl_addr),
        .ctrl_wdat   (ctrl_wdat),
        .frame_done  (frame_done),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [23:0] wdat;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   write_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   write_cnt = 0;
    int   done_cnt = 0;
    int   accepted = 0;
    logic grab65 = 1'b0;
    logic [15:0] addr65 = 16'hFFFF;
    logic [15:0] last_done_addr = 16'h0000;
    logic sender_done;

    // reference model state: 0 idle, 1 write, 2 drop
    int   m_state = 0;
    int   m_x = 0;
    int   m_y = 0;
    int   m_short = 0;
    int   m_long = 0;

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    always @(posedge ctrl_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int x, input int y, input logic [15:0] data);
        exp_t e;
        e.addr = 16'((x << 5) | y);
        e.wdat = {8'h00, data};
        e.done = (x == W - 1) && (y == H - 1);
        exp_q.push_back(e);
        if (e.done) begin
            m_state = 0;
            m_x = 0;
            m_y = 0;
        end else begin
            m_state = 1;
            m_x = (x == W - 1) ? 0 : x + 1;
            m_y = (x == W - 1) ? y + 1 : y;
        end
    endtask

    task automatic model_accept(input logic sof, input logic [15:0] data);
        accepted++;
        if (m_state == 1) begin
            if (sof) begin
                if (m_short < 255) m_short++;
                model_write(0, 0, data);
            end else begin
                model_write(m_x, m_y, data);
            end
        end else if (sof) begin
            model_write(0, 0, data);
        end else begin
            if (m_state == 0 && m_long < 255) m_long++;
            m_state = 2;
        end
    endtask

    // Compare every DUT write against the head of the expectation queue.
    always @(negedge ctrl_clk) begin
        if (ctrl_resetn) begin
            if (frame_done) begin
                done_cnt++;
                last_done_addr = ctrl_addr;
            end
            if (ctrl_en) begin
                exp_t e;
                write_cnt++;
                write_cyc.push_back(cyc);
                if (grab65 && ctrl_wdat == 24'd65) addr65 = ctrl_addr;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {31'd0, ctrl_en}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", {16'd0, ctrl_addr}, {16'd0, e.addr});
                    check("wdat", {8'd0, ctrl_wdat}, {8'd0, e.wdat});
                    check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
                    check("lanes", {28'd0, ctrl_wr}, 32'd7);
                end
            end else if (frame_done) begin
                check("done_without_en", {31'd0, frame_done}, 32'd0);
            end
        end
    end

    task automatic send(input logic sof, input logic [15:0] data);
        int n = 0;
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = data;
        while (!s_ready && n < 2000) begin
            @(posedge ctrl_clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            check("send_timeout", {31'd0, s_ready}, 32'd1);
        end else begin
            @(posedge ctrl_clk);
            model_accept(sof, data);
            #1;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 100) begin
            @(posedge ctrl_clk);
            #1;
            n++;
        end
        check("ready_after_reset", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge ctrl_clk);
            #1;
            n++;
        end
        repeat (4) @(posedge ctrl_clk);
        #1;
        check("drain", exp_q.size(), 32'd0);
    endtask

    task automatic send_frame(input logic [15:0] base, input int n_pix);
        send(1'b1, base);
        for (int i = 1; i < n_pix; i++) send(1'b0, 16'(base + 16'(i)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_ctrl_en"}, {31'd0, ctrl_en}, 32'd0);
        check({tag, "_ctrl_wr"}, {28'd0, ctrl_wr}, 32'd0);
        check({tag, "_ctrl_addr"}, {16'd0, ctrl_addr}, 32'd0);
        check({tag, "_ctrl_wdat"}, {8'd0, ctrl_wdat}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_err_short"}, {24'd0, err_short}, 32'd0);
        check({tag, "_err_long"}, {24'd0, err_long}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int w0;
        int a0;
        int n;
        ctrl_resetn = 1'b0;
        s_valid = 1'b0;
        s_sof = 1'b0;
        s_data = 16'h0000;
        hold = 1'b0;
        repeat (3) @(posedge ctrl_clk);
        #1;
        check_reset_outputs("reset");
        ctrl_resetn = 1'b1;
        wait_ready();

        // Full frame, data = index.
        grab65 = 1'b1;
        d0 = done_cnt;
        send_frame(16'd0, W * H);
        drain();
        grab65 = 1'b0;
        // pixel 65 sits at x=1, y=1 -> {x[5:0], y[4:0]} = 0x021
        check("addr_pix65", {16'd0, addr65}, 32'h0021);
        check("done_addr", {16'd0, last_done_addr}, 32'h07FF);
        check("frame1_done_cnt", done_cnt - d0, 32'd1);
        check("frame1_err_short", {24'd0, err_short}, 32'd0);
        check("frame1_err_long", {24'd0, err_long}, 32'd0);

        // Short frame of 101 pixels, then a complete frame starting at data 102.
        d0 = done_cnt;
        send_frame(16'd1, 101);
        send_frame(16'd102, W * H);
        drain();
        check("short_err_short", {24'd0, err_short}, 32'd1);
        check("short_err_long", {24'd0, err_long}, 32'd0);
        check("short_done_cnt", done_cnt - d0, 32'd1);

        // Complete frame, 5 stray pixels, another frame.
        d0 = done_cnt;
        w0 = write_cnt;
        send_frame(16'h1000, W * H);
        for (int i = 0; i < 5; i++) send(1'b0, 16'(16'hE000 + 16'(i)));
        send_frame(16'h2000, W * H);
        drain();
        check("long_err_long", {24'd0, err_long}, 32'd1);
        check("long_err_short", {24'd0, err_short}, 32'd1);
        check("long_write_cnt", write_cnt - w0, 32'(2 * W * H));
        check("long_done_cnt", done_cnt - d0, 32'd2);

        // Hold: the FIFO fills to 4 and nothing is written.
        hold = 1'b1;
        a0 = accepted;
        w0 = write_cnt;
        sender_done = 1'b0;
        fork
            begin
                send_frame(16'h3000, 6);
                sender_done = 1'b1;
            end
        join_none
        repeat (12) @(posedge ctrl_clk);
        #1;
        check("hold_accepted", accepted - a0, 32'd4);
        check("hold_s_ready", {31'd0, s_ready}, 32'd0);
        check("hold_no_write", write_cnt - w0, 32'd0);
        w0 = write_cyc.size();
        hold = 1'b0;
        n = 0;
        while (!sender_done && n < 200) begin
            @(posedge ctrl_clk);
            #1;
            n++;
        end
        check("hold_sender_done", {31'd0, sender_done}, 32'd1);
        drain();
        if (write_cyc.size() >= w0 + 4) begin
            check("hold_consecutive", write_cyc[w0 + 3] - write_cyc[w0], 32'd3);
        end else begin
            check("hold_write_count", write_cyc.size() - w0, 32'd4);
        end
        check("hold_ready_back", {31'd0, s_ready}, 32'd1);

        // Reset mid-frame with pixels buffered.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, 16'(16'h4000 + 16'(i)));
        repeat (2) @(posedge ctrl_clk);
        #1;
        ctrl_resetn = 1'b0;
        #2;
        check_reset_outputs("midreset");
        exp_q.delete();
        m_state = 0;
        m_x = 0;
        m_y = 0;
        m_short = 0;
        m_long = 0;
        hold = 1'b0;
        @(posedge ctrl_clk);
        #1;
        ctrl_resetn = 1'b1;
        wait_ready();
        send(1'b0, 16'h5555);
        send_frame(16'h1234, 8);
        drain();
        check("postreset_err_long", {24'd0, err_long}, 32'd1);
        check("postreset_err_short", {24'd0, err_short}, 32'd0);

        // Many short frames saturate the short counter.
        for (int i = 0; i < 300; i++) send_frame(16'(i), 2);
        drain();
        check("sat_err_short", {24'd0, err_short}, 32'd255);
        check("sat_model_short", {24'd0, err_short}, 32'(m_short));
        check("sat_err_long", {24'd0, err_long}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
